// File: rtl/alu_cnt_dec_core.sv
// alu_cnt_dec_core
//   Three independent registered utility functions on one clock/reset:
//     - 4-bit ALU (ADD, SUB, NOT, AND, OR, XOR, SLT, EQ) with zero/carry/overflow
//     - wrapping down-counter with enable
//     - 3-to-8 one-hot decoder with enable
//   Every output comes straight from a flop, so each has a 1-cycle latency.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset, clears every register
//   alu_fnselec[2:0] ALU operation select
//   alu_a, alu_b     ALU operands (two's complement for signed ops)
//   alu_res          registered ALU result
//   alu_zero         result == 0
//   alu_overflow     signed overflow (ADD/SUB only)
//   alu_carry        carry-out (ADD/SUB only; for SUB 1 = no borrow)
//   counter_en       decrement enable
//   dec_counter_out  registered counter value
//   x, en            decoder select / enable
//   y_dec            registered one-hot decode
//
// Build option
//   COUNTER_LOAD_EN  adds cnt_load / cnt_load_val; a load wins over decrement.

module alu_cnt_dec_core #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_fnselec,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_res,
    output logic             alu_zero,
    output logic             alu_overflow,
    output logic             alu_carry,
    input  logic             counter_en,
`ifdef COUNTER_LOAD_EN
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] cnt_load_val,
`endif
    output logic [CNT_W-1:0] dec_counter_out,
    input  logic [2:0]       x,
    input  logic             en,
    output logic [7:0]       y_dec
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] alu_res_d, alu_res_q;
    logic             alu_zero_d, alu_zero_q;
    logic             alu_overflow_d, alu_overflow_q;
    logic             alu_carry_d, alu_carry_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [7:0]       y_dec_d, y_dec_q;

    // Extended sums keep the carry-out in bit WIDTH.
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
    assign diff_ext = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (alu_a[MSB] == alu_b[MSB]) && (sum_ext[MSB]  != alu_a[MSB]);
    assign sub_ovf  = (alu_a[MSB] != alu_b[MSB]) && (diff_ext[MSB] != alu_a[MSB]);

    always_comb begin
        alu_res_d      = '0;
        alu_carry_d    = 1'b0;
        alu_overflow_d = 1'b0;
        case (alu_fnselec)
            3'b000: begin
                alu_res_d      = sum_ext[MSB:0];
                alu_carry_d    = sum_ext[WIDTH];
                alu_overflow_d = add_ovf;
            end
            3'b001: begin
                alu_res_d      = diff_ext[MSB:0];
                alu_carry_d    = diff_ext[WIDTH];
                alu_overflow_d = sub_ovf;
            end
            3'b010: alu_res_d = ~alu_a;
            3'b011: alu_res_d = alu_a & alu_b;
            3'b100: alu_res_d = alu_a | alu_b;
            3'b101: alu_res_d = alu_a ^ alu_b;
            // Signed less-than: sign of A-B corrected by its overflow.
            3'b110: alu_res_d = {{(WIDTH-1){1'b0}}, diff_ext[MSB] ^ sub_ovf};
            3'b111: alu_res_d = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
            default: alu_res_d = '0;
        endcase
        alu_zero_d = (alu_res_d == '0);
    end

    always_comb begin
        cnt_d = cnt_q;
`ifdef COUNTER_LOAD_EN
        if (cnt_load) begin
            cnt_d = cnt_load_val;
        end else if (counter_en) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        if (counter_en) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
`endif
    end

    always_comb begin
        y_dec_d = en ? (8'b0000_0001 << x) : 8'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q      <= '0;
            alu_zero_q     <= 1'b0;
            alu_overflow_q <= 1'b0;
            alu_carry_q    <= 1'b0;
            cnt_q          <= '0;
            y_dec_q        <= 8'b0;
        end else begin
            alu_res_q      <= alu_res_d;
            alu_zero_q     <= alu_zero_d;
            alu_overflow_q <= alu_overflow_d;
            alu_carry_q    <= alu_carry_d;
            cnt_q          <= cnt_d;
            y_dec_q        <= y_dec_d;
        end
    end

    assign alu_res         = alu_res_q;
    assign alu_zero        = alu_zero_q;
    assign alu_overflow    = alu_overflow_q;
    assign alu_carry       = alu_carry_q;
    assign dec_counter_out = cnt_q;
    assign y_dec           = y_dec_q;

endmodule

// File: tb/tb_alu_cnt_dec_core.sv
module tb_alu_cnt_dec_core;

    logic       clk;
    logic       rst;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic       counter_en;
    logic [2:0] dec_counter_out;
    logic [2:0] x;
    logic       en;
    logic [7:0] y_dec;
`ifdef COUNTER_LOAD_EN
    logic       cnt_load;
    logic [2:0] cnt_load_val;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state / expectations
    int m_cnt;
    int e_res, e_zero, e_ovf, e_carry, e_y;

    alu_cnt_dec_core #(.WIDTH(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_fnselec     (alu_fnselec),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_res         (alu_res),
        .alu_zero        (alu_zero),
        .alu_overflow    (alu_overflow),
        .alu_carry       (alu_carry),
        .counter_en      (counter_en),
`ifdef COUNTER_LOAD_EN
        .cnt_load        (cnt_load),
        .cnt_load_val    (cnt_load_val),
`endif
        .dec_counter_out (dec_counter_out),
        .x               (x),
        .en              (en),
        .y_dec           (y_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // ALU computed with plain integer arithmetic
    task automatic alu_model(input int f, input int a, input int b);
        int sa, sb, s;
        sa = to_signed4(a);
        sb = to_signed4(b);
        e_carry = 0;
        e_ovf   = 0;
        case (f)
            0: begin
                s = a + b;
                e_res = s % 16;
                e_carry = (s >= 16);
                e_ovf = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            1: begin
                e_res = (a - b + 16) % 16;
                e_carry = (a >= b);
                e_ovf = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
            2: e_res = 15 - a;
            3: e_res = a & b;
            4: e_res = a | b;
            5: e_res = a ^ b;
            6: e_res = (sa < sb) ? 1 : 0;
            default: e_res = (a == b) ? 1 : 0;
        endcase
        e_zero = (e_res == 0);
    endtask

    // Compute expectations from the current inputs, clock once, then compare.
    task automatic tick();
        alu_model(int'(alu_fnselec), int'(alu_a), int'(alu_b));
`ifdef COUNTER_LOAD_EN
        if (cnt_load) m_cnt = int'(cnt_load_val);
        else if (counter_en) m_cnt = (m_cnt + 7) % 8;
`else
        if (counter_en) m_cnt = (m_cnt + 7) % 8;
`endif
        e_y = en ? (1 << int'(x)) : 0;
        @(posedge clk);
        #1;
        chk("alu_res", 32'(alu_res), 32'(e_res));
        chk("alu_zero", 32'(alu_zero), 32'(e_zero));
        chk("alu_carry", 32'(alu_carry), 32'(e_carry));
        chk("alu_overflow", 32'(alu_overflow), 32'(e_ovf));
        chk("counter", 32'(dec_counter_out), 32'(m_cnt));
        chk("y_dec", 32'(y_dec), 32'(e_y));
    endtask

    task automatic alu_op(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        alu_fnselec = f;
        alu_a = a;
        alu_b = b;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_res"}, 32'(alu_res), 32'd0);
        chk({tag, "_zero"}, 32'(alu_zero), 32'd0);
        chk({tag, "_carry"}, 32'(alu_carry), 32'd0);
        chk({tag, "_ovf"}, 32'(alu_overflow), 32'd0);
        chk({tag, "_cnt"}, 32'(dec_counter_out), 32'd0);
        chk({tag, "_y"}, 32'(y_dec), 32'd0);
    endtask

    // Assert reset between edges and check outputs clear before any edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        #1;
        rst = 1'b0;
        m_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        alu_fnselec = 3'b000;
        alu_a = 4'h0;
        alu_b = 4'h0;
        counter_en = 1'b0;
        x = 3'd0;
        en = 1'b0;
`ifdef COUNTER_LOAD_EN
        cnt_load = 1'b0;
        cnt_load_val = 3'd0;
`endif
        m_cnt = 0;
        #1;
        check_all_zero("rst_t0");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst = 1'b0;

        // directed ALU vectors
        alu_op(3'b000, 4'b0111, 4'b0001);
        alu_op(3'b000, 4'b1111, 4'b0001);
        alu_op(3'b001, 4'b0000, 4'b0001);
        alu_op(3'b001, 4'b0101, 4'b0101);
        alu_op(3'b110, 4'b1000, 4'b0001);
        alu_op(3'b110, 4'b0001, 4'b1000);
        alu_op(3'b111, 4'b1010, 4'b1010);
        alu_op(3'b111, 4'b1010, 4'b1011);
        alu_op(3'b010, 4'b0000, 4'b0000);
        alu_op(3'b011, 4'b1100, 4'b1010);
        alu_op(3'b100, 4'b1100, 4'b1010);
        alu_op(3'b101, 4'b1100, 4'b1100);
        alu_op(3'b001, 4'b1000, 4'b0001);

        // counter: 7, 6, 5 then hold
        async_reset("rst_cnt");
        counter_en = 1'b1;
        repeat (3) tick();
        chk("cnt_after3", 32'(dec_counter_out), 32'd5);
        counter_en = 1'b0;
        repeat (2) tick();
        counter_en = 1'b1;
        tick();
        async_reset("rst_midcount");
        counter_en = 1'b0;

        // decoder
        en = 1'b1;
        x = 3'd5;
        tick();
        chk("dec_x5", 32'(y_dec), 32'h20);
        x = 3'd0;
        tick();
        en = 1'b0;
        tick();

`ifdef COUNTER_LOAD_EN
        counter_en = 1'b1;
        cnt_load = 1'b1;
        cnt_load_val = 3'd3;
        tick();
        chk("load_prio", 32'(dec_counter_out), 32'd3);
        cnt_load = 1'b0;
        counter_en = 1'b0;
`endif

        // randomized traffic on all three functions at once
        for (int i = 0; i < 400; i++) begin
            alu_fnselec = 3'($urandom_range(0, 7));
            alu_a = 4'($urandom_range(0, 15));
            alu_b = (($urandom_range(0, 7)) == 0) ? alu_a : 4'($urandom_range(0, 15));
            counter_en = 1'($urandom_range(0, 1));
            x = 3'($urandom_range(0, 7));
            en = 1'($urandom_range(0, 1));
`ifdef COUNTER_LOAD_EN
            cnt_load = ($urandom_range(0, 4) == 0);
            cnt_load_val = 3'($urandom_range(0, 7));
`endif
            tick();
            if (i == 200) begin
                en = 1'b1;
                counter_en = 1'b1;
                async_reset("rst_random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cnt_dec_core.md
Name: alu_cnt_dec_core

Overview:
- Small clocked utility block with three independent sub-functions sharing one clock and reset:
  - a 4-bit ALU with status flags,
  - a 3-bit wrapping down-counter with enable,
  - a 3-to-8 one-hot decoder with enable.
- All outputs are registered, so timing is uniform.
- Sits beside the board I/O glue; it feeds LEDs and seven-segment displays and is exercised by directed benches.

Parameters:
- WIDTH, 4, ALU operand/result width in bits.
- CNT_W, 3, down-counter width in bits (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset.
- alu_fnselec  input  3  ALU operation select.
- alu_a  input  WIDTH  operand A (two's complement for signed ops).
- alu_b  input  WIDTH  operand B.
- alu_res  output  WIDTH  registered ALU result.
- alu_zero  output  1  registered; 1 when the result is all zeros.
- alu_overflow  output  1  registered signed-overflow flag.
- alu_carry  output  1  registered carry-out flag.
- counter_en  input  1  decrement enable.
- dec_counter_out  output  CNT_W  registered counter value.
- x  input  3  decoder select.
- en  input  1  decoder enable.
- y_dec  output  8  registered one-hot decode.

Behaviour:
- Reset: while rst=1 (asynchronous, no clock needed):
  - alu_res=0, alu_zero=0, alu_overflow=0, alu_carry=0;
  - dec_counter_out=0;
  - y_dec=0.
- Releasing reset takes effect at the next rising clk edge.
- ALU: all outputs update at every rising edge from the current inputs, 1-cycle latency. Operations by alu_fnselec:
  - 000 ADD: res=A+B. carry=carry-out of bit WIDTH-1. overflow=(A[msb]==B[msb])&&(res[msb]!=A[msb]).
  - 001 SUB: computed as A+~B+1. carry=carry-out of that sum (1 = no borrow). overflow=(A[msb]!=B[msb])&&(res[msb]!=A[msb]).
  - 010 NOT: res=~A.
  - 011 AND: res=A&B.
  - 100 OR: res=A|B.
  - 101 XOR: res=A^B.
  - 110 SLT: res=1 if A<B signed, else 0. Derived as (sub_res[msb] XOR sub_overflow).
  - 111 EQ: res=1 if A==B, else 0.
- ALU flags:
  - carry and overflow are forced to 0 for every op other than ADD/SUB.
  - zero=(res==0) for every op, including NOT, logic, SLT and EQ.
- Down-counter:
  - At a rising edge with counter_en=1: dec_counter_out <= dec_counter_out-1, modulo 2^CNT_W, so 0 wraps to 7.
  - counter_en=0: holds its value.
  - No terminal-count output.
- Decoder:
  - At a rising edge, y_dec <= (en ? (8'b1 << x) : 8'b0).
  - Exactly one bit is set when enabled; all zeros when disabled.
- Sub-functions are fully independent; simultaneous activity on all three never interacts.
- Reset asserted mid-operation clears every register immediately, regardless of the enables.
- No X propagation on defined inputs. Every fnselec code is defined.

Optional Feature:
- Macro COUNTER_LOAD_EN.
- When defined, two extra inputs are added:
  - cnt_load (1 bit),
  - cnt_load_val (CNT_W bits).
- Load behaviour when defined:
  - At a rising edge with cnt_load=1, dec_counter_out <= cnt_load_val.
  - Load has priority over decrement.
  - rst still has priority over load.
- When undefined, the ports do not exist and the counter only resets/decrements/holds.

Test Plan:
- ADD overflow: fnselec=000, A=0111, B=0001; one edge -> res=1000, overflow=1, carry=0, zero=0.
- ADD wrap: fnselec=000, A=1111, B=0001 -> res=0000, carry=1, zero=1, overflow=0.
- SUB:
  - A=0000, B=0001 -> res=1111, carry=0, overflow=0.
  - A=0101, B=0101 -> res=0000, zero=1, carry=1.
- Compare:
  - SLT A=1000, B=0001 -> res=0001, zero=0.
  - SLT A=0001, B=1000 -> res=0000, zero=1.
  - EQ A=B=1010 -> res=0001.
  - Logic ops: NOT A=0000 -> res=1111, carry=overflow=0.
- Counter: assert rst -> out=0. Then counter_en=1 for 3 edges -> 7, 6, 5. Then counter_en=0 for 2 edges -> stays 5. Assert rst mid-count asynchronously -> 0 before the next edge.
- Decoder and reset:
  - en=1, x=5 -> y_dec=00100000.
  - x=0 -> 00000001.
  - en=0 -> 00000000.
  - Assert rst asynchronously -> all outputs 0 immediately.
  - With COUNTER_LOAD_EN: cnt_load=1, cnt_load_val=3 together with counter_en=1 -> 3.
